trencadis_regfile_writeback: RTL and testbench

Writeback arbiter that drives the single write port of the Trencadís register file from NUM_SRC independent producers, such as the ALU, load unit and CSR unit.
- Each producer hands off writes over a valid/ready handshake into a private FIFO.
- A round-robin arbiter drains one entry per cycle onto a registered write port (waddr_o/wdata_o/wen_o).
- A per-register pending bitmask is exported for hazard detection.

---
 rtl/trencadis_regfile_pkg.sv | 40 ++++
 rtl/trencadis_wb_fifo.sv | 75 +++++++
 rtl/trencadis_regfile_writeback.sv | 120 ++++++++++++
 tb/tb_trencadis_regfile_writeback.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trencadis_regfile_pkg.sv
// Shared constants, types and the round-robin pick function for the
// Trencadis register-file writeback arbiter.
package trencadis_regfile_pkg;

  // Default register-file geometry.
  localparam int DEF_REG_COUNT = 32;
  localparam int DEF_DEPTH     = 32;

  // Widest source count the round-robin helper can search.
  localparam int MAX_SRC   = 32;
  localparam int SRC_IDX_W = $clog2(MAX_SRC);

  // Result of a round-robin search: whether any requester was found and
  // which one.
  typedef struct packed {
    logic                 found;
    logic [SRC_IDX_W-1:0] idx;
  } rr_pick_t;

  // Returns the first set bit of req[n-1:0], searching ptr, ptr+1, ...
  // modulo n. ptr must be below n. The wrap is a single conditional
  // subtract, which avoids a general modulo operator.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0]   req,
                                       input logic [SRC_IDX_W-1:0] ptr,
                                       input logic [SRC_IDX_W:0]   n);
    rr_pick_t               res;
    logic [SRC_IDX_W:0]     cand;
    res = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      cand = {1'b0, ptr} + (SRC_IDX_W + 1)'(i);
      if (cand >= n) cand = cand - n;
      if (!res.found && (i < int'(n)) && req[cand[SRC_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[SRC_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/trencadis_wb_fifo.sv
// Small synchronous FIFO holding queued register writes for one producer.
// Exposes every slot (valid + data) so the parent can build a pending mask.
module trencadis_wb_fifo #(
  parameter int WIDTH     = 37,
  parameter int BUF_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [WIDTH-1:0]                din_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [WIDTH-1:0]                head_o,
  output logic [BUF_DEPTH-1:0]            entry_valid_o,
  output logic [BUF_DEPTH-1:0][WIDTH-1:0] entry_data_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;
  logic [BUF_DEPTH-1:0]           r_valid;
  logic [BUF_DEPTH-1:0][WIDTH-1:0] r_mem;

  logic w_push;
  logic w_pop;

  // Pointer increment that wraps at BUF_DEPTH, which need not be a power of 2.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o        = (r_count == CNT_W'(BUF_DEPTH));
  assign empty_o       = (r_count == '0);
  assign w_push        = push_i && !full_o;
  assign w_pop         = pop_i && !empty_o;
  assign head_o        = r_mem[r_rd_ptr];
  assign entry_valid_o = r_valid;
  assign entry_data_o  = r_mem;

  // Pointer, occupancy and per-slot valid bookkeeping.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A push and a pop never target the same slot: that would need the
      // FIFO to be both empty (no pop) and full (no push).
      if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
      if (w_push) r_valid[r_wr_ptr] <= 1'b1;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    // NOTE: the data array is deliberately left unreset; r_valid and r_count
    // decide which slots mean anything, so stale contents are harmless.
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

endmodule

// File: rtl/trencadis_regfile_writeback.sv
// Writeback arbiter for the Trencadis register file: per-producer FIFOs,
// round-robin drain onto one registered write port, and a pending mask of
// registers with writes still in flight.
module trencadis_regfile_writeback
  import trencadis_regfile_pkg::*;
#(
  parameter int NUM_SRC          = 2,
  parameter int REG_COUNT        = DEF_REG_COUNT,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int BUF_DEPTH        = 2,
  parameter int ZERO_REG_IS_ZERO = 1,
  localparam int ADDR_WIDTH      = $clog2(REG_COUNT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  src_waddr_i,
  input  logic [NUM_SRC-1:0][DEPTH-1:0]       src_wdata_i,
  output logic [ADDR_WIDTH-1:0]               waddr_o,
  output logic [DEPTH-1:0]                    wdata_o,
  output logic                                wen_o,
  output logic [REG_COUNT-1:0]                pending_o,
  output logic                                idle_o
);

  // Each queued entry is {addr, data}.
  localparam int ENTRY_W = ADDR_WIDTH + DEPTH;

  logic [NUM_SRC-1:0]                  w_full;
  logic [NUM_SRC-1:0]                  w_empty;
  logic [NUM_SRC-1:0]                  w_push;
  logic [NUM_SRC-1:0]                  w_grant;
  logic [ENTRY_W-1:0]                  w_head      [NUM_SRC];
  logic [BUF_DEPTH-1:0]                w_ent_valid [NUM_SRC];
  logic [BUF_DEPTH-1:0][ENTRY_W-1:0]   w_ent_data  [NUM_SRC];
  logic [ENTRY_W-1:0]                  w_grant_entry;
  logic [REG_COUNT-1:0]                w_pending;
  rr_pick_t                            w_pick;

  logic                   r_wen;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [DEPTH-1:0]       r_wdata;
  logic [SRC_IDX_W-1:0]   r_rr;

  // One FIFO per producer. A write to r0 with ZERO_REG_IS_ZERO set still
  // completes its handshake but is dropped instead of being queued.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic w_drop;
    assign w_drop         = (ZERO_REG_IS_ZERO != 0) && (src_waddr_i[s] == '0);
    assign src_ready_o[s] = !w_full[s] && !rst_i;
    assign w_push[s]      = src_valid_i[s] && src_ready_o[s] && !w_drop;
    assign w_grant[s]     = w_pick.found && (w_pick.idx == SRC_IDX_W'(s));

    trencadis_wb_fifo #(
      .WIDTH     (ENTRY_W),
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .push_i        (w_push[s]),
      .pop_i         (w_grant[s]),
      .din_i         ({src_waddr_i[s], src_wdata_i[s]}),
      .full_o        (w_full[s]),
      .empty_o       (w_empty[s]),
      .head_o        (w_head[s]),
      .entry_valid_o (w_ent_valid[s]),
      .entry_data_o  (w_ent_data[s])
    );
  end

  assign w_pick = rr_pick(MAX_SRC'(~w_empty), r_rr, (SRC_IDX_W + 1)'(NUM_SRC));

  // Select the head entry of the granted FIFO.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_grant_entry = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_grant[s]) w_grant_entry = w_head[s];
    end
  end

  // Registered write port and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rr    <= '0;
    end else if (w_pick.found) begin
      r_wen   <= 1'b1;
      r_waddr <= w_grant_entry[ENTRY_W-1 -: ADDR_WIDTH];
      r_wdata <= w_grant_entry[DEPTH-1:0];
      r_rr    <= (w_pick.idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0
                                                         : w_pick.idx + SRC_IDX_W'(1);
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // Pending mask: any queued entry or the write currently on the port.
  always_comb begin
    w_pending = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < BUF_DEPTH; e++) begin
        if (w_ent_valid[s][e]) w_pending[w_ent_data[s][e][ENTRY_W-1 -: ADDR_WIDTH]] = 1'b1;
      end
    end
    if (r_wen) w_pending[r_waddr] = 1'b1;
    if (ZERO_REG_IS_ZERO != 0) w_pending[0] = 1'b0;
  end

  assign waddr_o   = r_waddr;
  assign wdata_o   = r_wdata;
  assign wen_o     = r_wen;
  assign pending_o = w_pending;
  assign idle_o    = (&w_empty) && !r_wen;

endmodule

// File: tb/tb_trencadis_regfile_writeback.sv
// Directed bench for trencadis_regfile_writeback (2 sources, BUF_DEPTH 2).
// A second instance with ZERO_REG_IS_ZERO=0 shares all inputs.
module tb_trencadis_regfile_writeback;

  typedef logic [36:0] ent_t;  // {addr[4:0], data[31:0]}

  logic             clk;
  logic             rst;
  logic [1:0]       src_valid;
  logic [1:0]       src_ready;
  logic [1:0][4:0]  src_waddr;
  logic [1:0][31:0] src_wdata;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic             wen;
  logic [31:0]      pending;
  logic             idle;

  logic [1:0]       nz_ready;
  logic [4:0]       nz_waddr;
  logic [31:0]      nz_wdata;
  logic             nz_wen;
  logic [31:0]      nz_pending;
  logic             nz_idle;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ent_t       send0[$];
  ent_t       send1[$];
  ent_t       acc0[$];
  ent_t       acc1[$];
  ent_t       obs_q[$];
  int         obs_cyc[$];
  logic [1:0] ready_log[$];

  trencadis_regfile_writeback #(
    .NUM_SRC(2), .REG_COUNT(32), .DEPTH(32), .BUF_DEPTH(2), .ZERO_REG_IS_ZERO(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .waddr_o(waddr), .wdata_o(wdata), .wen_o(wen),
    .pending_o(pending), .idle_o(idle)
  );

  trencadis_regfile_writeback #(
    .NUM_SRC(2), .REG_COUNT(32), .DEPTH(32), .BUF_DEPTH(2), .ZERO_REG_IS_ZERO(0)
  ) dut_nz (
    .clk_i(clk), .rst_i(rst),
    .src_valid_i(src_valid), .src_ready_o(nz_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .waddr_o(nz_waddr), .wdata_o(nz_wdata), .wen_o(nz_wen),
    .pending_o(nz_pending), .idle_o(nz_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the head of each send queue to the DUT.
  task automatic drive();
    if (send0.size() != 0) begin
      src_valid[0] = 1'b1; src_waddr[0] = send0[0][36:32]; src_wdata[0] = send0[0][31:0];
    end else begin
      src_valid[0] = 1'b0; src_waddr[0] = '0; src_wdata[0] = '0;
    end
    if (send1.size() != 0) begin
      src_valid[1] = 1'b1; src_waddr[1] = send1[0][36:32]; src_wdata[1] = send1[0][31:0];
    end else begin
      src_valid[1] = 1'b0; src_waddr[1] = '0; src_wdata[1] = '0;
    end
  endtask

  // One clock: sample at negedge, advance producers just after posedge.
  task automatic cycle();
    logic [1:0] take;
    @(negedge clk);
    take = src_valid & src_ready;
    ready_log.push_back(src_ready);
    if (wen === 1'b1) begin
      obs_q.push_back({waddr, wdata});
      obs_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    if (take[0]) acc0.push_back(send0.pop_front());
    if (take[1]) acc1.push_back(send1.pop_front());
    cyc++;
    drive();
  endtask

  task automatic clear_logs();
    send0.delete(); send1.delete(); acc0.delete(); acc1.delete();
    obs_q.delete(); obs_cyc.delete(); ready_log.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int   exp3 [8];
    int   n_wen;
    int   n_nz;
    ent_t nz_seen;
    ent_t exp_e;
    logic s_now;
    logic s_prev;

    // ---- Test 1: reset with both valids high ----
    rst = 1'b1;
    src_valid = 2'b11; src_waddr[0] = 5'd3; src_waddr[1] = 5'd4;
    src_wdata[0] = 32'h1111_1111; src_wdata[1] = 32'h2222_2222;
    @(negedge clk);
    check("t1_ready_in_reset_a", src_ready, 2'b00);
    @(negedge clk);
    check("t1_ready_in_reset_b", src_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; src_valid = 2'b00;
    @(negedge clk);
    check("t1_wen", wen, 1'b0);
    check("t1_ready", src_ready, 2'b11);
    check("t1_idle", idle, 1'b1);
    check("t1_pending", pending, 32'h0);
    n_wen = 0;
    repeat (3) begin
      @(negedge clk);
      if (wen) n_wen++;
    end
    check("t1_no_accept_wen", n_wen, 0);
    check("t1_no_accept_idle", idle, 1'b1);

    // ---- Test 2: single write, latency and pending window ----
    @(posedge clk); #1;
    src_valid = 2'b01; src_waddr[0] = 5'd5; src_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t2_ready0", src_ready[0], 1'b1);
    check("t2_pend_before", pending[5], 1'b0);
    @(posedge clk); #1;                 // edge k: accepted
    src_valid = 2'b00;
    @(negedge clk);
    check("t2_pend_k", pending[5], 1'b1);
    check("t2_wen_k", wen, 1'b0);
    check("t2_idle_k", idle, 1'b0);
    @(negedge clk);                     // after edge k+1
    check("t2_wen_k1", wen, 1'b1);
    check("t2_waddr_k1", waddr, 5'd5);
    check("t2_wdata_k1", wdata, 32'hDEAD_BEEF);
    check("t2_pend_k1", pending[5], 1'b1);
    @(negedge clk);                     // after edge k+2
    check("t2_wen_k2", wen, 1'b0);
    check("t2_pend_k2", pending[5], 1'b0);
    check("t2_idle_k2", idle, 1'b1);

    // ---- Test 3: both sources, 4 writes each, from a fresh pointer ----
    pulse_reset();
    clear_logs();
    for (int a = 1; a <= 4; a++) begin
      send0.push_back({5'(a), 32'hA000_0000 + 32'(a)});
      send1.push_back({5'(a + 10), 32'hA000_0000 + 32'(a + 10)});
    end
    drive();
    repeat (12) cycle();
    exp3 = '{1, 11, 2, 12, 3, 13, 4, 14};
    check("t3_wen_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t3_addr_seq", obs_q[i][36:32], 5'(exp3[i]));
        check("t3_data_seq", obs_q[i][31:0], 32'hA000_0000 + 32'(exp3[i]));
      end
      check("t3_consecutive", obs_cyc[7] - obs_cyc[0], 7);
    end
    check("t3_ready_c2", ready_log[2], 2'b01);
    check("t3_ready_c3", ready_log[3], 2'b10);
    check("t3_acc0", acc0.size(), 4);
    check("t3_acc1", acc1.size(), 4);

    // ---- Test 4: continuous random traffic for 20 cycles ----
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      send0.push_back({5'($urandom_range(1, 15)), 32'($urandom())});
      send1.push_back({5'($urandom_range(16, 31)), 32'($urandom())});
    end
    drive();
    repeat (20) cycle();
    send0.delete(); send1.delete();
    drive();
    repeat (8) cycle();
    check("t4_accepted", acc0.size() + acc1.size(), 22);
    check("t4_written", obs_q.size(), 22);
    s_prev = 1'b0;
    for (int i = 0; i < obs_q.size(); i++) begin
      s_now = (obs_q[i][36:32] >= 5'd16);
      if (i > 0) check("t4_alternate", s_now, !s_prev);
      s_prev = s_now;
      if (!s_now && acc0.size() != 0) begin
        exp_e = acc0.pop_front();
        check("t4_src0_order", obs_q[i], exp_e);
      end else if (s_now && acc1.size() != 0) begin
        exp_e = acc1.pop_front();
        check("t4_src1_order", obs_q[i], exp_e);
      end else begin
        check("t4_unexpected_write", obs_q[i], 37'h0);
      end
    end

    // ---- Test 5: write to r0, with and without the zero-register rule ----
    src_valid = 2'b10; src_waddr[1] = 5'd0; src_wdata[1] = 32'h0000_1234;
    @(negedge clk);
    check("t5_ready1", src_ready[1], 1'b1);
    @(posedge clk); #1;                 // handshake completes here
    src_valid = 2'b00;
    n_wen = 0; n_nz = 0; nz_seen = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t5_idle_after_drop", idle, 1'b1);
        check("t5_pend0_zero", pending[0], 1'b0);
        check("t5_nz_pend0", nz_pending[0], 1'b1);
      end
      if (wen) n_wen++;
      if (nz_wen) begin
        n_nz++;
        nz_seen = {nz_waddr, nz_wdata};
      end
    end
    check("t5_no_wen", n_wen, 0);
    check("t5_nz_wen_count", n_nz, 1);
    check("t5_nz_write", nz_seen, {5'd0, 32'h0000_1234});

    // ---- Test 6: reset while both FIFOs hold entries ----
    @(posedge clk); #1;
    clear_logs();
    send0.push_back({5'd9, 32'h0000_0009});  // leaves the pointer at source 1
    drive();
    repeat (4) cycle();
    clear_logs();
    for (int a = 20; a <= 23; a++) send0.push_back({5'(a), 32'hB000_0000 + 32'(a)});
    for (int a = 24; a <= 27; a++) send1.push_back({5'(a), 32'hB000_0000 + 32'(a)});
    drive();
    repeat (3) cycle();
    check("t6_first_grant_src1", obs_q.size() > 0 ? obs_q[0][36:32] : 5'h1f, 5'd24);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_in_reset", src_ready, 2'b00);
    check("t6_wen_pre_reset", wen, 1'b1);
    check("t6_waddr_pre_reset", waddr, 5'd20);
    @(posedge clk); #1;
    rst = 1'b0;
    send0.delete(); send1.delete();
    drive();
    @(negedge clk);
    check("t6_wen_after", wen, 1'b0);
    check("t6_idle_after", idle, 1'b1);
    check("t6_pending_after", pending, 32'h0);
    n_wen = 0;
    repeat (5) begin
      @(negedge clk);
      if (wen) n_wen++;
    end
    check("t6_queued_lost", n_wen, 0);
    @(posedge clk); #1;
    clear_logs();
    send0.push_back({5'd7, 32'h0000_0007});
    send1.push_back({5'd8, 32'h0000_0008});
    drive();
    repeat (5) cycle();
    check("t6_post_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t6_post_first_src0", obs_q[0][36:32], 5'd7);
      check("t6_post_second_src1", obs_q[1][36:32], 5'd8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
